logic_op_sequencer: RTL and testbench

//  Upstream stimulus/capture stage for the AND/NAND selector (Guia_0701): walks the
//  8 {a,b,select} vectors, holds each HOLD_CYCLES clocks, then samples the selector's

---
 rtl/guia07_pkg.sv | 19 +
 rtl/vector_hold_timer.sv | 25 ++
 rtl/logic_op_sequencer.sv | 93 +++++++++
 tb/tb_logic_op_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/guia07_pkg.sv
// Shared types and constants for the AND/NAND selector stimulus sequencer.
package guia07_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int         NUM_VECTORS = 8;
  // Bit i is the expected selector output for vector i ({a,b,select} = i).
  localparam logic [7:0] GOLDEN_WORD = 8'h6A;

  function automatic logic golden_bit(input logic [2:0] idx);
    return GOLDEN_WORD[idx];
  endfunction

endpackage

// File: rtl/vector_hold_timer.sv
// Hold counter: counts enabled cycles and flags the last cycle of a vector's hold.
module vector_hold_timer #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  logic [HOLD_W-1:0] r_hold;

  // Expire is combinational so the FSM leaves DRIVE on the final hold cycle.
  assign expire = enable && (r_hold == HOLD_W'(HOLD_CYCLES - 1));

  // Count only while enabled; restart from zero on expiry or when cleared.
  always_ff @(posedge clk) begin
    if (reset || clear)  r_hold <= '0;
    else if (expire)     r_hold <= '0;
    else if (enable)     r_hold <= r_hold + HOLD_W'(1);
  end

endmodule

// File: rtl/logic_op_sequencer.sv
// Clocked stimulus/capture source for the AND/NAND selector: drives the eight
// {a,b,select} vectors, samples the selector result, and scores it against golden.
module logic_op_sequencer
  import guia07_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       result_in,
  output logic       a,
  output logic       b,
  output logic       select,
  output logic       busy,
  output logic       done,
  output logic [7:0] result_word,
  output logic [3:0] error_count,
  output logic       mismatch
);

  state_t     r_state, w_next;
  logic [2:0] r_idx;
  logic       w_expire, w_hold_en, w_hold_clr, w_driving;

  assign w_hold_en  = (r_state == DRIVE) && !pause;
  assign w_hold_clr = (r_state != DRIVE);

  vector_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_hold_clr),
    .enable (w_hold_en),
    .expire (w_expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; start is only honoured when not busy.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (start)   w_next = DRIVE;
      DRIVE:      if (w_expire) w_next = SAMPLE;
      SAMPLE:     w_next = (r_idx == 3'(NUM_VECTORS - 1)) ? DONE : DRIVE;
      default:    w_next = IDLE;
    endcase
  end

  // Vector index and capture/scoring registers; a new sweep clears the scores.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx       <= '0;
      result_word <= '0;
      error_count <= '0;
      mismatch    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_idx       <= '0;
            result_word <= '0;
            error_count <= '0;
            mismatch    <= 1'b0;
          end
        end
        SAMPLE: begin
          result_word[r_idx] <= result_in;
          if (result_in != golden_bit(r_idx)) begin
            error_count <= error_count + 4'd1;
            mismatch    <= 1'b1;
          end
          if (r_idx != 3'(NUM_VECTORS - 1)) r_idx <= r_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Operands come straight from idx, so they only move on the SAMPLE->DRIVE edge.
  assign w_driving = (r_state == DRIVE) || (r_state == SAMPLE);
  assign a         = w_driving & r_idx[2];
  assign b         = w_driving & r_idx[1];
  assign select    = w_driving & r_idx[0];
  assign busy      = w_driving;
  assign done      = (r_state == DONE);

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Bench for logic_op_sequencer driving an inline AND/NAND selector model.
module tb_logic_op_sequencer;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, pause = 1'b0, start3 = 1'b0, force0 = 1'b0;
  always #5 clk = ~clk;

  logic a, b, select, busy, done, mismatch, result_in;
  logic [7:0] result_word;
  logic [3:0] error_count;
  logic a3, b3, s3, busy3, done3, mis3, res3;
  logic [7:0] word3;
  logic [3:0] err3;

  // The selector under stimulus: select=0 -> AND, 1 -> NAND; force0 models a stuck output.
  assign result_in = force0 ? 1'b0 : (select ? ~(a & b) : (a & b));
  assign res3      = s3 ? ~(a3 & b3) : (a3 & b3);

  logic_op_sequencer #(.HOLD_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .result_in(result_in),
    .a(a), .b(b), .select(select), .busy(busy), .done(done),
    .result_word(result_word), .error_count(error_count), .mismatch(mismatch)
  );

  logic_op_sequencer #(.HOLD_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .pause(1'b0), .result_in(res3),
    .a(a3), .b(b3), .select(s3), .busy(busy3), .done(done3),
    .result_word(word3), .error_count(err3), .mismatch(mis3)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- timeline model (HOLD_CYCLES = 1) ----------------
  // Each vector occupies MH+1 unpaused cycles; the last of them is the capture cycle.
  localparam int MH = 1;
  bit         m_act = 0, m_done = 0, m_mis = 0, cmp_en = 0;
  int         m_t = 0, m_err = 0, mp, mv;
  logic [7:0] m_word = '0;
  bit         mr;

  function automatic bit sel_fn(input int v, input bit f0);
    bit va, vb, vs;
    va = v[2]; vb = v[1]; vs = v[0];
    if (f0) return 1'b0;
    return vs ? !(va && vb) : (va && vb);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_act = 0; m_done = 0; m_t = 0; m_word = '0; m_err = 0; m_mis = 0;
    end else if (m_act) begin
      mp = m_t % (MH + 1);
      mv = m_t / (MH + 1);
      if (mp == MH) begin
        mr = sel_fn(mv, force0);
        m_word[mv] = mr;
        if (mr != sel_fn(mv, 1'b0)) begin m_err++; m_mis = 1; end
        m_t++;
        if (mv == 7) begin m_act = 0; m_done = 1; end
      end else if (!pause) begin
        m_t++;
      end
    end else if (start) begin
      m_act = 1; m_done = 0; m_t = 0; m_word = '0; m_err = 0; m_mis = 0;
    end
  end

  // Per-cycle comparison of every output against the model, plus an operand trace.
  logic [2:0]  ev;
  logic [23:0] trace;
  int          tn = 0;
  logic [2:0]  lastv;
  always @(negedge clk) begin
    if (cmp_en) begin
      ev = m_act ? 3'(m_t / (MH + 1)) : 3'd0;
      chk("model", {a, b, select, busy, done, result_word, error_count, mismatch},
          {ev, m_act, m_done, m_word, 4'(m_err), m_mis});
      if (busy && tn < 8 && (tn == 0 || {a, b, select} != lastv)) begin
        trace[3*tn +: 3] = {a, b, select};
        lastv = {a, b, select};
        tn++;
      end
    end
  end

  // One sweep on the HOLD_CYCLES=1 instance; optional pause on vector pv and
  // an ignored start pulse on vector rv. Returns edges from the start edge to done.
  task automatic sweep(input bit f0, input int pv, input int plen, input int rv, output int edges);
    int pcnt; bit pdone, rdone;
    pcnt = 0; pdone = 0; rdone = 0;
    force0 = f0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_err", error_count, 0);
    chk("start_mis", mismatch, 0);
    chk("start_word", result_word, 0);
    edges = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin edges = n; break; end
      if (pause) begin
        chk("pause_hold", {a, b, select}, pv);
        pcnt--;
        if (pcnt == 0) pause = 1'b0;
      end else if (!pdone && pv >= 0 && busy && {a, b, select} == pv[2:0]) begin
        pause = 1'b1; pcnt = plen; pdone = 1;
      end
      if (!rdone && rv >= 0 && busy && {a, b, select} == rv[2:0]) begin
        start = 1'b1; rdone = 1;
      end
    end
    if (edges < 0) begin
      checks++; errors++;
      $display("FAIL sweep_timeout: done never rose within 200 edges");
    end
  endtask

  int e, b5;

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {a, b, select, busy, done, result_word, error_count, mismatch}, 0);
    chk("rst_outs3", {a3, b3, s3, busy3, done3, word3, err3, mis3}, 0);
    reset = 1'b0;
    cmp_en = 1;

    // 1: clean sweep
    tn = 0;
    sweep(0, -1, 0, -1, e);
    chk("t1_edges", e, 16);
    chk("t1_word", result_word, 8'h6A);
    chk("t1_err", error_count, 0);
    chk("t1_mis", mismatch, 0);
    chk("t1_trace", trace, 24'hFAC688);
    chk("t1_tn", tn, 8);
    chk("t1_model_pin", m_word, 8'h6A);

    // 2: selector output stuck at 0
    sweep(1, -1, 0, -1, e);
    chk("t2_edges", e, 16);
    chk("t2_word", result_word, 8'h00);
    chk("t2_err", error_count, 4);
    chk("t2_mis", mismatch, 1);

    // 5: restart from DONE clears scores (checked at start edge); start at vector 2 ignored
    sweep(0, -1, 0, 2, e);
    chk("t5_edges", e, 16);
    chk("t5_word", result_word, 8'h6A);
    chk("t5_err", error_count, 0);

    // 3: pause 5 cycles during vector 3
    sweep(0, 3, 5, -1, e);
    chk("t3_edges", e, 21);
    chk("t3_word", result_word, 8'h6A);

    // 4: reset in SAMPLE of vector 4, then a fresh sweep
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("t4_vec4", {busy, a, b, select}, 4'b1100);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t4_rst_outs", {a, b, select, busy, done, result_word, error_count, mismatch}, 0);
    reset = 1'b0;
    sweep(0, -1, 0, -1, e);
    chk("t4_edges", e, 16);
    chk("t4_word", result_word, 8'h6A);

    // 6: HOLD_CYCLES=3 instance
    @(posedge clk); #1 start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    e = -1; b5 = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (done3) begin e = n; break; end
      if (busy3 && {a3, b3, s3} == 3'b101) b5++;
    end
    chk("t6_edges", e, 32);
    chk("t6_vec5_cycles", b5, 4);
    chk("t6_word", word3, 8'h6A);
    chk("t6_err", err3, 0);
    chk("t6_mis", mis3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
